// File: rtl/raytracing_job_dispatcher_pkg.sv
// Shared types for the raytracing job dispatcher: fixed-point widths, colour and sphere types,
// frame size defaults and the dispatcher state enum.
package raytracing_job_dispatcher_pkg;

   localparam int unsigned FP_B          = 4;
   localparam int unsigned COORD_B       = 12;
   localparam int unsigned COLOR_B       = 24;
   localparam int unsigned DOTY_B        = 22;
   localparam int unsigned PX_Y_SQRD_B   = 18;
   localparam int unsigned S_Y_SQRD_B    = 20;
   localparam int unsigned H_RES_DEFAULT = 640;
   localparam int unsigned V_RES_DEFAULT = 480;

   typedef logic [COLOR_B-1:0] color_t;

   typedef struct packed {
      logic signed [COORD_B-1:0] x;
      logic signed [COORD_B-1:0] y;
      logic signed [COORD_B-1:0] z;
      logic        [COORD_B-1:0] radius;
   } sphere_t;

   typedef enum logic [2:0] {
      IDLE,
      ROW_SETUP,
      ACTIVATE,
      WAIT_HI,
      WAIT_LO,
      RELEASE,
      DRAIN,
      NEXT
   } dispatch_state_e;

endpackage

// File: rtl/raytracing_job_dispatcher_rt_row_setup.sv
// Per-row shared values for the worker array: y**2 and y*sphere.y registered on load_row,
// sphere.y**2 >>> FP_B registered when a frame's sphere is latched.
module rt_row_setup
   import raytracing_job_dispatcher_pkg::*;
#(
   parameter int unsigned V_RES = V_RES_DEFAULT,
   parameter int unsigned ROW_B = 9
) (
   input  logic                       clk,
   input  logic                       rst_,
   input  logic                       load_sphere,
   input  logic                       load_row,
   input  logic signed [COORD_B-1:0]  sphere_y,
   input  logic        [ROW_B-1:0]    row,
   output logic signed [DOTY_B-1:0]   doty_r,
   output logic        [PX_Y_SQRD_B-1:0] pixel_y_sqrd,
   output logic        [S_Y_SQRD_B-1:0]  sphere_y_sqrd
);

   logic signed [COORD_B-1:0]   sphere_y_q;
   logic signed [2*COORD_B-1:0] y_w;
   logic signed [2*COORD_B-1:0] sy_w;

   // Operands are pre-widened so the products keep their full width before truncation.
   assign y_w  = (2*COORD_B)'(row) - (2*COORD_B)'(V_RES/2);
   assign sy_w = (2*COORD_B)'(sphere_y);

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         sphere_y_q    <= '0;
         sphere_y_sqrd <= '0;
         doty_r        <= '0;
         pixel_y_sqrd  <= '0;
      end else begin
         if (load_sphere) begin
            sphere_y_q    <= sphere_y;
            sphere_y_sqrd <= S_Y_SQRD_B'((sy_w * sy_w) >>> FP_B);
         end
         if (load_row) begin
            doty_r       <= DOTY_B'(y_w * (2*COORD_B)'(sphere_y_q));
            pixel_y_sqrd <= PX_Y_SQRD_B'(y_w * y_w);
         end
      end
   end

endmodule

// File: rtl/raytracing_job_dispatcher.sv
// Frame-level job dispatcher: activates the worker array batch by batch and drains results
// to the framebuffer in pixel order. Optional watchdog: RT_DISPATCH_TIMEOUT_EN.
module raytracing_job_dispatcher
   import raytracing_job_dispatcher_pkg::*;
#(
   parameter int unsigned N_WORKERS        = 4,
   parameter int unsigned JOBS_SUBDIVISION = 8,
   parameter int unsigned H_RES            = H_RES_DEFAULT,
   parameter int unsigned V_RES            = V_RES_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES   = 4096
) (
   input  logic                                             clk,
   input  logic                                             rst_,
   input  logic                                             frame_start,
   input  sphere_t                                          sphere,
   output logic [N_WORKERS-1:0]                             activate,
   output logic [N_WORKERS-1:0][COORD_B-1:0]                pixel_start_x,
   output logic signed [DOTY_B-1:0]                         doty_r,
   output logic [PX_Y_SQRD_B-1:0]                           pixel_y_sqrd,
   output logic [S_Y_SQRD_B-1:0]                            sphere_y_sqrd,
   input  logic [N_WORKERS-1:0]                             busy,
   input  color_t [N_WORKERS-1:0][JOBS_SUBDIVISION-1:0]     buffer,
   output logic                                             fb_valid,
   input  logic                                             fb_ready,
   output logic [$clog2(H_RES*V_RES)-1:0]                   fb_addr,
   output color_t                                           fb_color,
   output logic                                             frame_busy,
   output logic                                             frame_done,
   output logic                                             timeout_err
);

   localparam int unsigned B     = N_WORKERS * JOBS_SUBDIVISION;
   localparam int unsigned ROW_B = (V_RES > 1) ? $clog2(V_RES) : 1;
   localparam int unsigned COL_B = $clog2(H_RES);
   localparam int unsigned K_B   = $clog2(B);
   localparam int unsigned W_B   = (N_WORKERS > 1) ? $clog2(N_WORKERS) : 1;
   localparam int unsigned J_B   = (JOBS_SUBDIVISION > 1) ? $clog2(JOBS_SUBDIVISION) : 1;
   localparam int unsigned A_B   = $clog2(H_RES*V_RES);

   dispatch_state_e  state_q, state_d;
   logic [ROW_B-1:0] row_q;
   logic [COL_B-1:0] c0_q;
   logic [K_B-1:0]   k_q;
   logic             last_col, last_row;
   logic [W_B-1:0]   wi;
   logic [J_B-1:0]   ji;
   logic             tmo_hit, tmo_batch;
   logic             unused_sphere_bits;

   assign unused_sphere_bits = ^{sphere.x, sphere.z, sphere.radius};
   assign last_col = (c0_q == COL_B'(H_RES - B));
   assign last_row = (row_q == ROW_B'(V_RES - 1));
   assign wi       = W_B'(32'(k_q) % N_WORKERS);
   assign ji       = J_B'(32'(k_q) / N_WORKERS);

   rt_row_setup #(
      .V_RES (V_RES),
      .ROW_B (ROW_B)
   ) u_row_setup (
      .clk           (clk),
      .rst_          (rst_),
      .load_sphere   (state_q == IDLE && frame_start),
      .load_row      (state_q == ROW_SETUP),
      .sphere_y      (sphere.y),
      .row           (row_q),
      .doty_r        (doty_r),
      .pixel_y_sqrd  (pixel_y_sqrd),
      .sphere_y_sqrd (sphere_y_sqrd)
   );

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (frame_start) state_d = ROW_SETUP;
         ROW_SETUP: state_d = ACTIVATE;
         ACTIVATE:  state_d = WAIT_HI;
         WAIT_HI:   if (&busy) state_d = WAIT_LO;
         WAIT_LO:   if (~|busy) state_d = RELEASE;
         RELEASE:   state_d = DRAIN;
         DRAIN:     if (fb_ready && k_q == K_B'(B - 1)) state_d = NEXT;
         NEXT:      state_d = !last_col ? ACTIVATE : (last_row ? IDLE : ROW_SETUP);
         default:   state_d = IDLE;
      endcase
      if (tmo_hit) state_d = RELEASE;
   end

   always_comb begin
      activate      = '0;
      pixel_start_x = '0;
      fb_valid      = 1'b0;
      fb_addr       = '0;
      fb_color      = '0;
      frame_busy    = (state_q != IDLE);
      if (state_q inside {ACTIVATE, WAIT_HI, WAIT_LO}) begin
         activate = '1;
         for (int unsigned w = 0; w < N_WORKERS; w++)
            pixel_start_x[w] = COORD_B'(c0_q) - COORD_B'(H_RES/2) + COORD_B'(w);
      end
      if (state_q == DRAIN) begin
         fb_valid = 1'b1;
         fb_addr  = A_B'(32'(row_q) * H_RES + 32'(c0_q) + 32'(k_q));
         fb_color = tmo_batch ? '0 : buffer[wi][ji];
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         row_q      <= '0;
         c0_q       <= '0;
         k_q        <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state_q)
            IDLE: if (frame_start) begin
               row_q <= '0;
               c0_q  <= '0;
               k_q   <= '0;
            end
            DRAIN: if (fb_ready) k_q <= (k_q == K_B'(B - 1)) ? '0 : k_q + 1'b1;
            NEXT: begin
               if (!last_col) begin
                  c0_q <= c0_q + COL_B'(B);
               end else begin
                  c0_q <= '0;
                  if (last_row) frame_done <= 1'b1;
                  else          row_q      <= row_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef RT_DISPATCH_TIMEOUT_EN
   localparam int unsigned T_B = $clog2(TIMEOUT_CYCLES + 1);

   logic [T_B-1:0] tmo_cnt_q;
   logic           in_wait;
   logic           tmo_batch_q;
   logic           timeout_err_q;

   // One counter spans both wait states so the limit bounds the whole batch.
   assign in_wait     = (state_q inside {WAIT_HI, WAIT_LO});
   assign tmo_hit     = in_wait && (tmo_cnt_q == T_B'(TIMEOUT_CYCLES - 1));
   assign tmo_batch   = tmo_batch_q;
   assign timeout_err = timeout_err_q;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         tmo_cnt_q     <= '0;
         tmo_batch_q   <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         tmo_cnt_q <= in_wait ? tmo_cnt_q + 1'b1 : '0;
         if (tmo_hit) begin
            tmo_batch_q   <= 1'b1;
            timeout_err_q <= 1'b1;
         end else if (state_q == NEXT) begin
            tmo_batch_q <= 1'b0;
         end
      end
   end
`else
   localparam int unsigned UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;

   assign tmo_hit     = 1'b0;
   assign tmo_batch   = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_raytracing_job_dispatcher.sv
// Directed bench for raytracing_job_dispatcher with a small worker model returning colour = column.
// The watchdog scenario is included when RT_DISPATCH_TIMEOUT_EN is defined.
module tb_raytracing_job_dispatcher;
   import raytracing_job_dispatcher_pkg::*;

   localparam int unsigned NW = 2, NJ = 4, HR = 16, VR = 2;
   localparam int unsigned BATCH = NW * NJ, NPIX = HR * VR;

   logic clk = 1'b0, rst_ = 1'b0, frame_start = 1'b0;
   sphere_t sphere;
   logic [NW-1:0]              activate;
   logic [NW-1:0][COORD_B-1:0] pixel_start_x;
   logic signed [DOTY_B-1:0]   doty_r;
   logic [PX_Y_SQRD_B-1:0]     pixel_y_sqrd;
   logic [S_Y_SQRD_B-1:0]      sphere_y_sqrd;
   logic [NW-1:0]              busy;
   color_t [NW-1:0][NJ-1:0]    buffer;
   logic                       fb_valid, fb_ready = 1'b1;
   logic [4:0]                 fb_addr;
   color_t                     fb_color;
   logic                       frame_busy, frame_done, timeout_err;

   int checks = 0, errors = 0;
   int exp_addr = 0, n_writes = 0, n_done = 0, n_act = 0, sph_y = 100;
   logic toggle_mode = 1'b0, tmo_zero = 1'b0, stuck = 1'b0;
   logic prev_act = 1'b0, held_valid = 1'b0;
   logic [4:0] held_addr;
   color_t held_color;
   int bfm_state, bfm_cnt;

   raytracing_job_dispatcher #(
      .N_WORKERS        (NW),
      .JOBS_SUBDIVISION (NJ),
      .H_RES            (HR),
      .V_RES            (VR),
      .TIMEOUT_CYCLES   (16)
   ) dut (
      .clk           (clk),
      .rst_          (rst_),
      .frame_start   (frame_start),
      .sphere        (sphere),
      .activate      (activate),
      .pixel_start_x (pixel_start_x),
      .doty_r        (doty_r),
      .pixel_y_sqrd  (pixel_y_sqrd),
      .sphere_y_sqrd (sphere_y_sqrd),
      .busy          (busy),
      .buffer        (buffer),
      .fb_valid      (fb_valid),
      .fb_ready      (fb_ready),
      .fb_addr       (fb_addr),
      .fb_color      (fb_color),
      .frame_busy    (frame_busy),
      .frame_done    (frame_done),
      .timeout_err   (timeout_err)
   );

   always #5 clk = ~clk;

   // Worker model: busy one cycle after activate, idle again after a few cycles, colour = column.
   always @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         busy <= '0; bfm_state <= 0; bfm_cnt <= 0;
      end else if (!activate[0]) begin
         busy <= '0; bfm_state <= 0;
      end else if (bfm_state == 0) begin
         busy <= '1; bfm_cnt <= 0; bfm_state <= 1;
         for (int w = 0; w < NW; w++)
            for (int j = 0; j < NJ; j++)
               buffer[w][j] <= color_t'(32'($signed(pixel_start_x[w])) + HR/2 + j*NW);
      end else if (bfm_state == 1) begin
         bfm_cnt <= bfm_cnt + 1;
         if (bfm_cnt == 3) begin
            busy <= stuck ? 2'b10 : 2'b00;
            bfm_state <= 2;
         end
      end
   end

   task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int exp_color(input int addr);
      return (tmo_zero && addr < BATCH) ? 0 : addr % HR;
   endfunction

   task automatic check_row_values();
      int batch, row, c0, y;
      batch = exp_addr / BATCH;
      row   = batch / (HR / BATCH);
      c0    = (batch % (HR / BATCH)) * BATCH;
      y     = row - VR/2;
      check("activate_all", activate, 2'b11);
      check("doty_r", $signed(doty_r), y * sph_y);
      check("pixel_y_sqrd", pixel_y_sqrd, y * y);
      for (int w = 0; w < NW; w++)
         check("pixel_start_x", $signed(pixel_start_x[w]), c0 - HR/2 + w);
   endtask

   // Advances one cycle; drives fb_ready and observes the write port and activate.
   task automatic tick();
      @(negedge clk);
      fb_ready = toggle_mode ? ~fb_ready : 1'b1;
      if (!rst_) begin
         exp_addr = 0; held_valid = 1'b0; prev_act = 1'b0;
      end else begin
         if (held_valid && fb_valid) begin
            check("hold_addr", fb_addr, held_addr);
            check("hold_color", fb_color, held_color);
         end
         held_valid = fb_valid && !fb_ready;
         held_addr  = fb_addr;
         held_color = fb_color;
         if (fb_valid && fb_ready) begin
            check("addr", fb_addr, exp_addr);
            check("color", fb_color, exp_color(exp_addr));
            exp_addr = (exp_addr + 1) % NPIX;
            n_writes++;
         end
         if (activate[0] && !prev_act) begin
            n_act++;
            check_row_values();
         end
         prev_act = activate[0];
         if (frame_done) n_done++;
      end
   endtask

   task automatic start_frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check("frame_busy_after_start", frame_busy, 1);
   endtask

   task automatic wait_done(input string tag, input int d0);
      int n = 0;
      while (n_done == d0 && n < 3000) begin tick(); n++; end
      check({tag, "_done_in_time"}, n < 3000, 1);
   endtask

   task automatic check_frame(input string tag, input int w0, input int a0, input int d0);
      check({tag, "_writes"}, n_writes - w0, NPIX);
      check({tag, "_activates"}, n_act - a0, NPIX / BATCH);
      check({tag, "_done_count"}, n_done - d0, 1);
      check({tag, "_busy_at_done"}, frame_busy, 0);
   endtask

   task automatic run_frame(input string tag, input int poke_at);
      int w0, a0, d0;
      w0 = n_writes; a0 = n_act; d0 = n_done;
      start_frame();
      if (poke_at > 0) begin
         repeat (poke_at) tick();
         frame_start = 1'b1;
         tick();
         frame_start = 1'b0;
      end
      wait_done(tag, d0);
      check_frame(tag, w0, a0, d0);
      tick();
      check({tag, "_done_pulse_width"}, frame_done, 0);
   endtask

   initial begin
      int w0, a0, d0, n;
      sphere = '0;
      sphere.y = 12'sd100;

      repeat (2) tick();
      check("rst_activate", activate, 0);
      check("rst_fb_valid", fb_valid, 0);
      check("rst_frame_busy", frame_busy, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_doty_r", doty_r, 0);
      check("rst_sphere_y_sqrd", sphere_y_sqrd, 0);
      check("rst_timeout_err", timeout_err, 0);
      rst_ = 1'b1;
      tick();

      // Frame 1: fb_ready high, explicit row-0/batch-0 values
      w0 = n_writes; a0 = n_act; d0 = n_done;
      start_frame();
      check("sphere_y_sqrd", sphere_y_sqrd, 625);
      n = 0;
      while (!activate[0] && n < 20) begin tick(); n++; end
      check("first_activate_seen", activate[0], 1);
      check("row0_doty_r", $signed(doty_r), -100);
      check("row0_pixel_y_sqrd", pixel_y_sqrd, 1);
      check("batch0_psx0", $signed(pixel_start_x[0]), -8);
      check("batch0_psx1", $signed(pixel_start_x[1]), -7);
      wait_done("frame1", d0);
      check_frame("frame1", w0, a0, d0);

      // Back-to-back: frame_start in the frame_done cycle
      w0 = n_writes; a0 = n_act; d0 = n_done;
      start_frame();
      wait_done("frame2", d0);
      check_frame("frame2", w0, a0, d0);
      tick();

      // fb_ready toggling: stall stability checked in tick
      toggle_mode = 1'b1;
      run_frame("stall", 0);
      toggle_mode = 1'b0;

      // frame_start mid-frame is ignored
      run_frame("midstart", 20);

      // Reset during drain of batch 1
      w0 = n_writes;
      start_frame();
      n = 0;
      while (!(fb_valid && n_writes - w0 >= BATCH + 2) && n < 500) begin tick(); n++; end
      check("reached_batch1_drain", fb_valid, 1);
      rst_ = 1'b0;
      #1;
      check("midrst_activate", activate, 0);
      check("midrst_fb_valid", fb_valid, 0);
      check("midrst_fb_addr", fb_addr, 0);
      check("midrst_frame_busy", frame_busy, 0);
      check("midrst_doty_r", doty_r, 0);
      check("midrst_pixel_y_sqrd", pixel_y_sqrd, 0);
      w0 = n_writes;
      repeat (3) tick();
      check("midrst_no_writes", n_writes - w0, 0);
      check("midrst_fb_valid_held", fb_valid, 0);
      rst_ = 1'b1;
      tick();
      run_frame("after_reset", 0);

`ifdef RT_DISPATCH_TIMEOUT_EN
      // Worker 1 stuck busy during batch 0
      stuck = 1'b1;
      tmo_zero = 1'b1;
      w0 = n_writes; a0 = n_act; d0 = n_done;
      start_frame();
      n = 0;
      while (!activate[0] && n < 20) begin tick(); n++; end
      check("tmo_activate_seen", activate[0], 1);
      n = 0;
      while (!timeout_err && n < 100) begin tick(); n++; end
      check("tmo_cycles", n, 17);
      check("tmo_err_set", timeout_err, 1);
      stuck = 1'b0;
      wait_done("tmo_frame", d0);
      check_frame("tmo_frame", w0, a0, d0);
      check("tmo_err_sticky", timeout_err, 1);
      tmo_zero = 1'b0;
`else
      check("timeout_err_tied", timeout_err, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
